// File: rtl/bdm_pkg.sv
// Shared BDM definitions used by the target-side SYNC responder and the
// host-side sync controller.
//   sync_resp_state_t     : responder FSM states
//   BDM_SYNC_TGT_CYCLES   : SYNC pulse / response length in target BDC clocks
//   BDM_SETTLE_TGT_CYCLES : gap between host release and target response,
//                           in target BDC clocks
package bdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    SETTLE,
    DRIVE_LOW,
    SPEEDUP
  } sync_resp_state_t;

  localparam int BDM_SYNC_TGT_CYCLES   = 128;
  localparam int BDM_SETTLE_TGT_CYCLES = 16;

endpackage

// File: rtl/bdm_sync_2ff.sv
// Two-flop synchronizer for the asynchronous BKGD pad level.
// Resets to 1 because the idle BKGD line is pulled high, so a reset never
// looks like the start of a low pulse.
//   clk : system clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output (stage 2)
module bdm_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/bdm_sync_responder.sv
// Target-side end of the BDM SYNC handshake. Measures a host low pulse on
// BKGD; if it is long enough, waits a settle time after the host releases,
// drives BKGD low for RESP_LEN clocks, drives a short high speedup pulse,
// then releases the line.
//   clk           : system clock
//   rst           : synchronous, active-high reset
//   enable        : responder armed (only looked at in IDLE)
//   bkgd_in       : raw BKGD pad level, asynchronous
//   bkgd_out      : value driven onto BKGD when bkgd_oe=1
//   bkgd_oe       : pad output enable
//   busy          : FSM not in IDLE
//   sync_detected : one-cycle pulse when a qualifying request is accepted
//   sync_done     : one-cycle pulse when the response completes
//   req_low_count : host low time in clk cycles of the last accepted request
module bdm_sync_responder
  import bdm_pkg::*;
#(
  parameter int TGT_CLK_DIV    = 4,
  parameter int SYNC_MIN       = BDM_SYNC_TGT_CYCLES * TGT_CLK_DIV,
  parameter int SETTLE_CYCLES  = BDM_SETTLE_TGT_CYCLES * TGT_CLK_DIV,
  parameter int RESP_LEN       = BDM_SYNC_TGT_CYCLES * TGT_CLK_DIV,
  parameter int SPEEDUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bkgd_in,
  output logic        bkgd_out,
  output logic        bkgd_oe,
  output logic        busy,
  output logic        sync_detected,
  output logic        sync_done,
  output logic [31:0] req_low_count
);

  localparam int MAX_T = (SETTLE_CYCLES > RESP_LEN) ?
                         ((SETTLE_CYCLES > SPEEDUP_CYCLES) ? SETTLE_CYCLES : SPEEDUP_CYCLES) :
                         ((RESP_LEN > SPEEDUP_CYCLES) ? RESP_LEN : SPEEDUP_CYCLES);
  localparam int TMR_W = $clog2(MAX_T) + 1;

  logic             w_s;
  sync_resp_state_t r_state;
  logic [31:0]      r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_oe;
  logic             r_out;
  logic             r_busy;
  logic             r_det;
  logic             r_done;
  logic [31:0]      r_req_cnt;

  bdm_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bkgd_in),
    .q   (w_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_oe      <= 1'b0;
      r_out     <= 1'b1;
      r_busy    <= 1'b0;
      r_det     <= 1'b0;
      r_done    <= 1'b0;
      r_req_cnt <= '0;
    end else begin
      r_det  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && !w_s) begin
            r_state <= MEASURE;
            r_cnt   <= 32'd1;
            r_busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (!w_s) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
          end else if (r_cnt >= 32'(SYNC_MIN)) begin
            r_req_cnt <= r_cnt;
            r_det     <= 1'b1;
            r_state   <= SETTLE;
            r_timer   <= TMR_W'(SETTLE_CYCLES - 1);
          end else begin
            // Too short to be a SYNC: drop it silently.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SETTLE: begin
          if (!w_s) begin
            // Host pulled the line again before we answered: re-measure.
            r_state <= MEASURE;
            r_cnt   <= 32'd1;
          end else if (r_timer == '0) begin
            r_state <= DRIVE_LOW;
            r_timer <= TMR_W'(RESP_LEN - 1);
            r_oe    <= 1'b1;
            r_out   <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        DRIVE_LOW: begin
          // w_s is our own drive here, so it is not looked at.
          if (r_timer == '0) begin
            r_state <= SPEEDUP;
            r_timer <= TMR_W'(SPEEDUP_CYCLES - 1);
            r_out   <= 1'b1;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        SPEEDUP: begin
          if (r_timer == '0) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bkgd_out      = r_out;
  assign bkgd_oe       = r_oe;
  assign busy          = r_busy;
  assign sync_detected = r_det;
  assign sync_done     = r_done;
  assign req_low_count = r_req_cnt;

endmodule

// File: tb/tb_bdm_sync_responder.sv
// Self-checking bench for bdm_sync_responder: directed cases plus randomized
// pulse widths, checked against an outcome model derived from the SYNC rules.
module tb_bdm_sync_responder;

  localparam int DIV      = 4;
  localparam int SYNC_MIN = 128 * DIV;
  localparam int SETTLE   = 16 * DIV;
  localparam int RESP     = 128 * DIV;
  localparam int SPD      = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        host_drv;
  logic        lb;
  logic        bkgd_in;
  logic        bkgd_out;
  logic        bkgd_oe;
  logic        busy;
  logic        sync_detected;
  logic        sync_done;
  logic [31:0] req_low_count;

  // Open-drain wired line when lb=1; otherwise the bench alone drives it.
  assign bkgd_in = host_drv & ~(lb & bkgd_oe & ~bkgd_out);

  always #5 clk = ~clk;

  bdm_sync_responder #(
    .TGT_CLK_DIV    (DIV),
    .SYNC_MIN       (SYNC_MIN),
    .SETTLE_CYCLES  (SETTLE),
    .RESP_LEN       (RESP),
    .SPEEDUP_CYCLES (SPD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bkgd_in       (bkgd_in),
    .bkgd_out      (bkgd_out),
    .bkgd_oe       (bkgd_oe),
    .busy          (busy),
    .sync_detected (sync_detected),
    .sync_done     (sync_done),
    .req_low_count (req_low_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int det_n, done_n, low_n, hi_n, wire_low;
  int rise_c, fall_c, done_c, low_first, low_last;
  bit prev_oe = 1'b0;
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sync_detected) det_n++;
    if (sync_done) begin
      done_n++;
      done_c = cyc;
    end
    if (bkgd_oe && !bkgd_out) begin
      low_n++;
      if (low_first < 0) low_first = cyc;
      low_last = cyc;
    end
    if (bkgd_oe && bkgd_out) hi_n++;
    if (bkgd_oe && !prev_oe && rise_c < 0) rise_c = cyc;
    if (!bkgd_oe && prev_oe) fall_c = cyc;
    if (lb && host_drv && !bkgd_in) wire_low++;
    prev_oe = bkgd_oe;
  endtask

  task automatic clear_mon();
    det_n = 0; done_n = 0; low_n = 0; hi_n = 0; wire_low = 0;
    rise_c = -1; fall_c = -1; done_c = -1; low_first = -1; low_last = -1;
  endtask

  task automatic pulse_low(input int n);
    host_drv = 1'b0;
    repeat (n) tick();
    host_drv = 1'b1;
  endtask

  function automatic bit qualifies(input int n);
    return n >= SYNC_MIN;
  endfunction

  // One host request (optionally re-driven gap cycles after release), then
  // compare every observable against the outcome the SYNC rules predict.
  task automatic run_case(input string nm, input int n, input bit en,
                          input int gap, input int n2);
    int rel;
    bit first_ok, last_ok;
    int exp_det;
    clear_mon();
    enable = en;
    pulse_low(n);
    rel = cyc;
    first_ok = en && qualifies(n);
    last_ok  = first_ok;
    exp_det  = first_ok ? 1 : 0;
    if (gap > 0) begin
      repeat (gap) tick();
      pulse_low(n2);
      rel = cyc;
      last_ok = en && qualifies(n2);
      exp_det += last_ok ? 1 : 0;
      if (last_ok) model_cnt = n2;
      else if (first_ok) model_cnt = n;
    end else if (first_ok) begin
      model_cnt = n;
    end
    repeat (SETTLE + RESP + SPD + 24) tick();
    chk({nm, "/det"},  32'(det_n), 32'(exp_det));
    chk({nm, "/done"}, 32'(done_n), last_ok ? 32'd1 : 32'd0);
    chk({nm, "/lowlen"}, 32'(low_n), last_ok ? 32'(RESP) : 32'd0);
    chk({nm, "/hilen"},  32'(hi_n),  last_ok ? 32'(SPD) : 32'd0);
    chk({nm, "/count"}, req_low_count, 32'(model_cnt));
    if (last_ok) begin
      chk({nm, "/oe_rise"}, 32'(rise_c - (rel + 1)), 32'(SETTLE + 2));
      chk({nm, "/low_contig"}, 32'(low_last - low_first + 1), 32'(RESP));
      chk({nm, "/fall"}, 32'(fall_c - low_last), 32'(SPD + 1));
      chk({nm, "/done_at_fall"}, 32'(done_c), 32'(fall_c));
    end
    chk({nm, "/end_oe"},   32'(bkgd_oe), 32'd0);
    chk({nm, "/end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; host_drv = 1'b1; lb = 1'b0;
    clear_mon();
    repeat (3) tick();
    chk("rst/oe",    32'(bkgd_oe), 32'd0);
    chk("rst/out",   32'(bkgd_out), 32'd1);
    chk("rst/busy",  32'(busy), 32'd0);
    chk("rst/det",   32'(sync_detected), 32'd0);
    chk("rst/done",  32'(sync_done), 32'd0);
    chk("rst/count", req_low_count, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    run_case("nominal",  6500, 1'b1, 0, 0);
    run_case("glitch",   SYNC_MIN - 1, 1'b1, 0, 0);
    run_case("boundary", SYNC_MIN, 1'b1, 0, 0);
    run_case("redrive",  600, 1'b1, 10, 700);
    run_case("disabled", 6500, 1'b0, 0, 0);

    // Reset in the middle of the low drive.
    clear_mon();
    enable = 1'b1;
    pulse_low(1000);
    for (int i = 0; i < 2000 && low_n < 200; i++) tick();
    chk("midrst/reached", 32'(low_n), 32'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    chk("midrst/oe",   32'(bkgd_oe), 32'd0);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/out",  32'(bkgd_out), 32'd1);
    repeat (RESP + 20) tick();
    chk("midrst/no_done", 32'(done_n), 32'd0);
    chk("midrst/count",   req_low_count, 32'd0);

    // Loopback on a wired-AND line: the host times the target's low pulse.
    lb = 1'b1;
    run_case("loopback", 6500, 1'b1, 0, 0);
    chk("loopback/len_ok",
        32'((wire_low >= RESP - 2) && (wire_low <= RESP + 2)), 32'd1);
    lb = 1'b0;

    for (int k = 0; k < 10; k++) begin
      int n;
      bit en;
      if ($urandom_range(1, 0) == 1) n = SYNC_MIN - 4 + int'($urandom_range(8, 0));
      else n = 1 + int'($urandom_range(1199, 0));
      en = ($urandom_range(3, 0) != 0);
      run_case($sformatf("rand%0d", k), n, en, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
